instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Decoupled instruction fetch stage for the 64-bit ARM datapath. It sits directly upstream of the decode/control stage. It owns the fetch PC and issues in-order word requests to a variable-latency instruction memory. Returned instructions are buffered, each with its PC, in a small queue that presents one instruction per cycle to decode over a valid/ready handshake. A taken-branch redirect flushes the queue and discards stale in-flight responses.

## Interface
- `DEPTH`, 4 — queue entries; power of two, ≥2; also the maximum number of outstanding requests.
- `RESET_PC`, 64'h0 — fetch address after reset.

- `clk` in 1 — clock; all state updates on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `redirect` in 1 — branch taken; flush and restart fetch.
- `redirect_pc` in 64 — new fetch address; bits [1:0] ignored, treated as 0.
- `imem_req_valid` out 1 — request valid.
- `imem_req_ready` in 1 — memory accepts the request.
- `imem_req_addr` out 64 — word-aligned fetch address.
- `imem_resp_valid` in 1 — response valid. Responses return in request order, at least 1 cycle after acceptance, with no backpressure.
- `imem_resp_data` in 32 — instruction word.
- `dec_valid` out 1 — head entry valid.
- `dec_ready` in 1 — decode accepts the head entry.
- `dec_pc` out 64 — PC of the head instruction.
- `dec_ins` out 32 — head instruction.
- `perf_fetched` out 32 — present only with `IFQ_PERF_EN`.
- `perf_stall` out 32 — present only with `IFQ_PERF_EN`.

## Operation
- **State**
  - `fetch_pc` (64b).
  - Circular buffer of DEPTH entries {pc, ins, filled}.
  - Pointers `head`, `fill`, `tail`.
  - `alloc` = entries allocated (0..DEPTH).
  - `drop` = stale responses still expected (0..DEPTH).
- **Issue**
  - `imem_req_valid` = !reset && (alloc + drop < DEPTH).
  - `imem_req_addr` = `fetch_pc`.
  - On request fire: allocate entry at `tail` with pc=`fetch_pc`, filled=0; advance `tail`; `fetch_pc` += 4.
  - `fetch_pc` wraps modulo 2^64.
- **Response**
  - If `drop` > 0: discard the response and decrement `drop`.
  - Else if an unfilled allocated entry exists: write ins into the entry at `fill`, set filled, advance `fill`.
  - Else: ignore the response.
- **Output**
  - `dec_valid` = entry at `head` allocated and filled.
  - `dec_pc`/`dec_ins` come from the head entry.
  - On fire (`dec_valid && dec_ready`): advance `head`, decrement `alloc`.
  - Request fire, response fill and decode pop in the same cycle are all legal.
  - Queue full (alloc=DEPTH) blocks issue only, never fill.
- **Redirect** (evaluated after same-cycle handshakes)
  - A decode pop in the redirect cycle completes normally.
  - `drop_next` = `drop` + unfilled_alloc + req_fire − resp_fire.
  - All entries are cleared: alloc=0, pointers reset to 0.
  - `fetch_pc` = {`redirect_pc`[63:2], 2'b00}.
- **Reset** (wins over everything)
  - `fetch_pc`=RESET_PC; alloc, drop, pointers and perf counters all = 0.
  - `dec_valid`=0 and `imem_req_valid`=0 while `reset`=1.
  - The memory is reset on the same `reset`; responses arriving afterwards with nothing outstanding are ignored.

## Timing
- Fill-to-decode latency: response in cycle N → `dec_valid` in cycle N+1. There is no bypass path.
- Reset deasserted before cycle 0, with memory latency 1: request in cycle 0, response in cycle 1, `dec_valid` in cycle 2.
- Throughput: 1 instruction/cycle while memory latency ≤ DEPTH−1 and decode is ready.
- `dec_pc`/`dec_ins` stay stable while `dec_valid && !dec_ready`.
- Redirect in cycle N → `imem_req_addr`=redirect target in cycle N+1, provided credit is available.
- Earliest `dec_valid` for the target: N+1 + latency + 1.

## Configuration
- **`IFQ_PERF_EN` defined:**
  - `perf_fetched` increments on every decode fire.
  - `perf_stall` increments on every cycle with `dec_ready`=1 and `dec_valid`=0 outside reset.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- **Not defined:** the perf ports and counters are absent; all other behaviour is identical.

## Test plan
1. Reset, memory latency 1, `dec_ready`=1 → `dec_pc` = 0x0, 0x4, 0x8, 0xC on consecutive cycles starting cycle 2, with `dec_ins` matching memory words.
2. `dec_ready`=0, memory latency 1 → exactly 4 request fires (0x0..0xC), then `imem_req_valid`=0. Outputs hold 0x0. Raising `dec_ready` drains 0x0..0xC in order and fetch resumes at 0x10.
3. Latency 3, `redirect`=1 with `redirect_pc`=0x100 while 2 requests are in flight → those 2 responses are discarded. The next `dec_pc` values are 0x100, then 0x104, and stale instructions never appear.
4. `redirect_pc`=0x103 → next `imem_req_addr`=0x100.
5. `imem_req_ready` toggling 1,0,1,0 → `imem_req_addr` advances only on fire. `dec_pc` sequence is 0x0, 0x4, 0x8 with no gaps or duplicates.
6. `reset` mid-stream with 3 entries queued → `dec_valid`=0 the next cycle, then the first request after release has `imem_req_addr`=RESET_PC. With `IFQ_PERF_EN`, both counters read 0.

Source files
------------

// File: rtl/instruction_fetch_queue_if.sv
// rtl/instruction_fetch_queue_if.sv - fetch/memory/decode handshake bundle for instruction_fetch_queue
interface instruction_fetch_queue_if;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [63:0] dec_pc;
  logic [31:0] dec_ins;

  // Fetch stage side
  modport master (
    input  redirect, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output dec_valid, dec_pc, dec_ins,
    input  dec_ready
  );

  // Environment side: branch unit, instruction memory and decode
  modport slave (
    output redirect, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  dec_valid, dec_pc, dec_ins,
    output dec_ready
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - decoupled fetch stage with PC queue; optional perf counters under IFQ_PERF_EN
module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic                        clk,
  input logic                        reset,
  instruction_fetch_queue_if.master  bus
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]                perf_fetched,
  output logic [31:0]                perf_stall
`endif
);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int CW1 = CW + 1;

  logic [63:0]   r_fetch_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_fill;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_alloc;
  logic [CW-1:0] r_unfilled;
  logic [CW-1:0] r_drop;
  logic [63:0]   r_pc  [DEPTH];
  logic [31:0]   r_ins [DEPTH];

  logic          w_credit;
  logic          w_req_fire;
  logic          w_resp_drop;
  logic          w_resp_fill;
  logic          w_head_ready;
  logic          w_dec_fire;
  logic [63:0]   w_redirect_target;
  logic [CW-1:0] w_drop_redirect;

  // Filled entries always sit at head..fill-1, so the head is ready exactly
  // when some allocated entry is not among the unfilled ones.
  assign w_credit          = ({1'b0, r_alloc} + {1'b0, r_drop}) < CW1'(DEPTH);
  assign w_req_fire        = bus.imem_req_valid && bus.imem_req_ready;
  assign w_resp_drop       = bus.imem_resp_valid && (r_drop != '0);
  assign w_resp_fill       = bus.imem_resp_valid && (r_drop == '0) && (r_unfilled != '0);
  assign w_head_ready      = (r_alloc != r_unfilled);
  assign w_dec_fire        = bus.dec_valid && bus.dec_ready;
  assign w_redirect_target = bus.redirect_pc & ~64'h3;
  // Everything still owed by memory after this cycle becomes stale on redirect.
  assign w_drop_redirect   = r_drop + r_unfilled + CW'(w_req_fire)
                           - CW'(w_resp_drop || w_resp_fill);

  assign bus.imem_req_valid = !reset && w_credit;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.dec_valid      = !reset && w_head_ready;
  assign bus.dec_pc         = r_pc[r_head];
  assign bus.dec_ins        = r_ins[r_head];

  // Control state: fetch PC, ring pointers, occupancy and stale-response count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_alloc    <= '0;
      r_unfilled <= '0;
      r_drop     <= '0;
    end else if (bus.redirect) begin
      r_fetch_pc <= w_redirect_target;
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_alloc    <= '0;
      r_unfilled <= '0;
      r_drop     <= w_drop_redirect;
    end else begin
      if (w_req_fire) begin
        r_tail     <= r_tail + AW'(1);
        r_fetch_pc <= r_fetch_pc + 64'd4;
      end
      if (w_resp_fill) r_fill <= r_fill + AW'(1);
      if (w_dec_fire)  r_head <= r_head + AW'(1);
      r_alloc    <= r_alloc + CW'(w_req_fire) - CW'(w_dec_fire);
      r_unfilled <= r_unfilled + CW'(w_req_fire) - CW'(w_resp_fill);
      if (w_resp_drop) r_drop <= r_drop - CW'(1);
    end
  end

  // Entry payload: PC captured at issue, instruction captured at fill
  always_ff @(posedge clk) begin
    if (w_req_fire)  r_pc[r_tail]  <= r_fetch_pc;
    if (w_resp_fill) r_ins[r_fill] <= bus.imem_resp_data;
  end

`ifdef IFQ_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  // Saturating counters for delivered instructions and decode starvation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_dec_fire && (r_perf_fetched != 32'hFFFF_FFFF))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (bus.dec_ready && !bus.dec_valid && (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - vector table, directed corner cases and randomized run against a queue-level model
module tb_instruction_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_queue_if bus();
`ifdef IFQ_PERF_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IFQ_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;

  logic        t_rst, t_redir, t_rr, t_dr;
  logic [63:0] t_rpc;
  logic        exp_rv, exp_dv;

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
  mreq_t       mq[$];
  logic [63:0] m_inflight[$];
  ent_t        m_ready[$];
  int          m_drop;
  logic [63:0] m_fetch;
  logic [63:0] fired[$];
  int          fired_cyc[$];

  typedef struct packed {
    logic        rst;
    logic        dr;
    logic        rr;
    logic        ev;
    logic [63:0] ea;
    logic        dv;
    logic [63:0] dp;
  } vec_t;
  vec_t vt[19];

  function automatic vec_t mk(logic rst, logic dr, logic ev, logic [63:0] ea, logic dv, logic [63:0] dp);
    vec_t v;
    v.rst = rst; v.dr = dr; v.rr = 1'b1; v.ev = ev; v.ea = ea; v.dv = dv; v.dp = dp;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = a[33:2] * 32'h9E37_79B1;
    return w ^ 32'h5A5A_0F0F ^ a[63:32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Drive this cycle's inputs and compare outputs against the model.
  task automatic drive_and_check();
    reset = t_rst;
    bus.redirect = t_redir;
    bus.redirect_pc = t_rpc;
    bus.imem_req_ready = t_rr;
    bus.dec_ready = t_dr;
    if (!t_rst && mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data = mem_word(mq[0].addr);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data = $urandom;
    end
    exp_rv = !t_rst && ((m_ready.size() + m_inflight.size() + m_drop) < DEPTH);
    exp_dv = !t_rst && (m_ready.size() > 0);
    #1;
    chk("req_valid", {63'd0, bus.imem_req_valid}, {63'd0, exp_rv});
    if (exp_rv) chk("req_addr", bus.imem_req_addr, m_fetch);
    chk("dec_valid", {63'd0, bus.dec_valid}, {63'd0, exp_dv});
    if (exp_dv) begin
      chk("dec_pc", bus.dec_pc, m_ready[0].pc);
      chk("dec_ins", {32'd0, bus.dec_ins}, {32'd0, m_ready[0].ins});
      chk("dec_ins_vs_mem", {32'd0, bus.dec_ins}, {32'd0, mem_word(bus.dec_pc)});
    end
  endtask

  // Advance memory and model across the clock edge.
  task automatic advance();
    logic [63:0] pc;
    if (bus.dec_valid && bus.dec_ready) begin
      fired.push_back(bus.dec_pc);
      fired_cyc.push_back(cyc);
    end
    if (bus.imem_resp_valid) void'(mq.pop_front());
    if (bus.imem_req_valid && bus.imem_req_ready)
      mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
    if (t_rst) begin
      mq.delete();
      m_inflight.delete();
      m_ready.delete();
      m_drop = 0;
      m_fetch = 64'h0;
    end else begin
      if (exp_dv && t_dr) void'(m_ready.pop_front());
      if (bus.imem_resp_valid) begin
        if (m_drop > 0) m_drop--;
        else if (m_inflight.size() > 0) begin
          pc = m_inflight.pop_front();
          m_ready.push_back('{pc: pc, ins: bus.imem_resp_data});
        end
      end
      if (exp_rv && t_rr) begin
        m_inflight.push_back(m_fetch);
        m_fetch = m_fetch + 64'd4;
      end
      if (t_redir) begin
        m_drop += m_inflight.size();
        m_inflight.delete();
        m_ready.delete();
        m_fetch = t_rpc & ~64'h3;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc = t_rst ? 0 : cyc + 1;
  endtask

  task automatic step();
    drive_and_check();
    advance();
  endtask

  task automatic do_reset();
    t_rst = 1'b1; t_redir = 1'b0;
    step();
    t_rst = 1'b0;
    fired.delete();
    fired_cyc.delete();
  endtask

  task automatic run_until_fired(input int n, input int budget);
    for (int k = 0; k < budget && fired.size() < n; k++) step();
    chk("fire_count", 64'(fired.size() >= n), 64'd1);
  endtask

  initial begin
    t_rst = 1'b1; t_redir = 1'b0; t_rpc = 64'h0; t_rr = 1'b1; t_dr = 1'b1;
    m_drop = 0; m_fetch = 64'h0;
    @(negedge clk);

    // Reset, steady stream, then full-queue stall and drain (latency 1)
    vt[0]  = mk(1, 1, 0, 64'h0,  0, 64'h0);
    vt[1]  = mk(0, 1, 1, 64'h0,  0, 64'h0);
    vt[2]  = mk(0, 1, 1, 64'h4,  0, 64'h0);
    vt[3]  = mk(0, 1, 1, 64'h8,  1, 64'h0);
    vt[4]  = mk(0, 1, 1, 64'hC,  1, 64'h4);
    vt[5]  = mk(0, 1, 1, 64'h10, 1, 64'h8);
    vt[6]  = mk(0, 1, 1, 64'h14, 1, 64'hC);
    vt[7]  = mk(1, 0, 0, 64'h0,  0, 64'h0);
    vt[8]  = mk(0, 0, 1, 64'h0,  0, 64'h0);
    vt[9]  = mk(0, 0, 1, 64'h4,  0, 64'h0);
    vt[10] = mk(0, 0, 1, 64'h8,  1, 64'h0);
    vt[11] = mk(0, 0, 1, 64'hC,  1, 64'h0);
    vt[12] = mk(0, 0, 0, 64'h0,  1, 64'h0);
    vt[13] = mk(0, 0, 0, 64'h0,  1, 64'h0);
    vt[14] = mk(0, 1, 0, 64'h0,  1, 64'h0);
    vt[15] = mk(0, 1, 1, 64'h10, 1, 64'h4);
    vt[16] = mk(0, 1, 1, 64'h14, 1, 64'h8);
    vt[17] = mk(0, 1, 1, 64'h18, 1, 64'hC);
    vt[18] = mk(0, 1, 1, 64'h1C, 1, 64'h10);
    lat = 1;
    for (int i = 0; i < 19; i++) begin
      t_rst = vt[i].rst; t_dr = vt[i].dr; t_rr = vt[i].rr; t_redir = 1'b0;
      drive_and_check();
      chk($sformatf("tbl%0d_req_valid", i), {63'd0, bus.imem_req_valid}, {63'd0, vt[i].ev});
      if (vt[i].ev) chk($sformatf("tbl%0d_req_addr", i), bus.imem_req_addr, vt[i].ea);
      chk($sformatf("tbl%0d_dec_valid", i), {63'd0, bus.dec_valid}, {63'd0, vt[i].dv});
      if (vt[i].dv) chk($sformatf("tbl%0d_dec_pc", i), bus.dec_pc, vt[i].dp);
      advance();
    end

    // Redirect with two requests in flight at latency 3
    lat = 3; t_dr = 1'b1; t_rr = 1'b1;
    do_reset();
    step();
    t_redir = 1'b1; t_rpc = 64'h100;
    step();
    t_redir = 1'b0;
    drive_and_check();
    chk("redir_addr", bus.imem_req_addr, 64'h100);
    chk("redir_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    advance();
    run_until_fired(2, 40);
    if (fired.size() >= 2) begin
      chk("redir_pc0", fired[0], 64'h100);
      chk("redir_pc1", fired[1], 64'h104);
      chk("redir_first_cycle", 64'(fired_cyc[0]), 64'd6);
    end

    // Unaligned redirect target
    lat = 1;
    do_reset();
    t_redir = 1'b1; t_rpc = 64'h103;
    step();
    t_redir = 1'b0;
    drive_and_check();
    chk("align_addr", bus.imem_req_addr, 64'h100);
    advance();
    run_until_fired(1, 20);
    if (fired.size() >= 1) chk("align_pc0", fired[0], 64'h100);

    // Request backpressure toggling
    do_reset();
    for (int i = 0; i < 14; i++) begin
      t_rr = (i % 2 == 0);
      step();
    end
    t_rr = 1'b1;
    run_until_fired(3, 20);
    if (fired.size() >= 3) begin
      chk("toggle_pc0", fired[0], 64'h0);
      chk("toggle_pc1", fired[1], 64'h4);
      chk("toggle_pc2", fired[2], 64'h8);
    end

    // Reset with queued entries
    do_reset();
    t_dr = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_reset_valid", {63'd0, bus.dec_valid}, 64'd1);
    do_reset();
    drive_and_check();
    chk("post_reset_dec_valid", {63'd0, bus.dec_valid}, 64'd0);
    chk("post_reset_addr", bus.imem_req_addr, 64'h0);
`ifdef IFQ_PERF_EN
    chk("perf_fetched_reset", {32'd0, perf_fetched}, 64'd0);
    chk("perf_stall_reset", {32'd0, perf_stall}, 64'd0);
`endif
    advance();

    // Randomized traffic with redirects, latency changes, wrap and resets
    t_dr = 1'b1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) lat = $urandom_range(1, 5);
      t_dr = ($urandom_range(0, 3) != 0);
      t_rr = ($urandom_range(0, 3) != 0);
      t_redir = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) t_rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else t_rpc = {$urandom, $urandom};
      t_rst = ($urandom_range(0, 499) == 0);
      step();
    end
    t_rst = 1'b0; t_redir = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
